// File: rtl/rally_sequencer.sv
// Match-level controller: frame divider, rally FSM (serve / play / point / over),
// score keeping, engine reset pulse generation and an engine handshake watchdog.
module rally_sequencer #(
  parameter int unsigned FRAME_DIV    = 416667,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned POINT_FRAMES = 90,
  parameter int unsigned WIN_SCORE    = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       pause,
  input  logic [7:0] btn_in,
  input  logic       phys_game_over,
  input  logic [1:0] phys_winner,
  input  logic       phys_valid,
  output logic [7:0] btn_out,
  output logic       phys_en,
  output logic       phys_rst_n,
  output logic [2:0] state,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic [1:0] match_winner,
  output logic       handshake_err
);

  localparam int unsigned DIV_W      = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam int unsigned MAX_FRAMES = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
  localparam int unsigned FRM_W      = $clog2(MAX_FRAMES + 1);

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(FRAME_DIV - 1);
  localparam logic [FRM_W-1:0] SERVE_LAST = FRM_W'(SERVE_FRAMES - 1);
  localparam logic [FRM_W-1:0] POINT_LAST = FRM_W'(POINT_FRAMES - 1);
  localparam logic [3:0]       WIN        = 4'(WIN_SCORE);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SERVE = 3'd1;
  localparam logic [2:0] S_PLAY  = 3'd2;
  localparam logic [2:0] S_POINT = 3'd3;
  localparam logic [2:0] S_OVER  = 3'd4;

  logic [DIV_W-1:0] div;
  logic [FRM_W-1:0] frame_cnt;
  logic             tick;
  logic             frame_step;
  logic             wd_active;
  logic [1:0]       wd_cnt;

  assign tick       = (div == DIV_LAST);
  assign frame_step = tick && !pause;

  // Free-running frame divider, independent of FSM state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div <= '0;
    end else if (tick) begin
      div <= '0;
    end else begin
      div <= div + DIV_W'(1);
    end
  end

  // Rally FSM with registered engine controls; phys_rst_n defaults high and is
  // pulled low for the single cycle in which a new serve begins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      frame_cnt    <= '0;
      p1_score     <= '0;
      p2_score     <= '0;
      match_winner <= '0;
      phys_en      <= 1'b0;
      phys_rst_n   <= 1'b0;
      btn_out      <= '0;
    end else begin
      phys_rst_n <= 1'b1;
      phys_en    <= tick && (state == S_PLAY) && !pause;
      btn_out    <= ((state == S_PLAY) && !pause) ? btn_in : '0;

      case (state)
        S_IDLE: begin
          if (start) begin
            state      <= S_SERVE;
            frame_cnt  <= '0;
            phys_rst_n <= 1'b0;
          end
        end

        S_SERVE: begin
          if (frame_step) begin
            if (frame_cnt == SERVE_LAST) begin
              state     <= S_PLAY;
              frame_cnt <= '0;
            end else begin
              frame_cnt <= frame_cnt + FRM_W'(1);
            end
          end
        end

        S_PLAY: begin
          if (phys_game_over) begin
            state     <= S_POINT;
            frame_cnt <= '0;
            if (phys_winner == 2'd1 && p1_score != 4'hF) begin
              p1_score <= p1_score + 4'd1;
            end else if (phys_winner == 2'd2 && p2_score != 4'hF) begin
              p2_score <= p2_score + 4'd1;
            end
          end
        end

        S_POINT: begin
          if (frame_step) begin
            if (frame_cnt == POINT_LAST) begin
              frame_cnt <= '0;
              if (p1_score >= WIN) begin
                state        <= S_OVER;
                match_winner <= 2'd1;
              end else if (p2_score >= WIN) begin
                state        <= S_OVER;
                match_winner <= 2'd2;
              end else begin
                state      <= S_SERVE;
                phys_rst_n <= 1'b0;
              end
            end else begin
              frame_cnt <= frame_cnt + FRM_W'(1);
            end
          end
        end

        S_OVER: begin
          if (start) begin
            state        <= S_SERVE;
            frame_cnt    <= '0;
            p1_score     <= '0;
            p2_score     <= '0;
            match_winner <= '0;
            phys_rst_n   <= 1'b0;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  // Handshake watchdog: each frame enable opens a 4-cycle window for phys_valid.
  // The timeout test runs ahead of the re-arm so a back-to-back enable cannot mask it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_active     <= 1'b0;
      wd_cnt        <= '0;
      handshake_err <= 1'b0;
    end else begin
      if (wd_active && !phys_valid && wd_cnt == 2'd3) begin
        handshake_err <= 1'b1;
      end
      if (phys_en) begin
        wd_active <= 1'b1;
        wd_cnt    <= '0;
      end else if (wd_active) begin
        if (phys_valid || wd_cnt == 2'd3) begin
          wd_active <= 1'b0;
        end else begin
          wd_cnt <= wd_cnt + 2'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rally_sequencer.sv
// Self-checking bench for rally_sequencer with a small divider-phase model,
// vector tables for button gating and rallies, and a scoreboard queue.
module tb_rally_sequencer;

  localparam int unsigned FD = 4;
  localparam int unsigned SF = 2;
  localparam int unsigned PF = 3;
  localparam int unsigned WS = 2;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SERVE = 3'd1;
  localparam logic [2:0] S_PLAY  = 3'd2;
  localparam logic [2:0] S_POINT = 3'd3;
  localparam logic [2:0] S_OVER  = 3'd4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       pause;
  logic [7:0] btn_in;
  logic       phys_game_over;
  logic [1:0] phys_winner;
  logic       phys_valid;
  logic [7:0] btn_out;
  logic       phys_en;
  logic       phys_rst_n;
  logic [2:0] state;
  logic [3:0] p1_score;
  logic [3:0] p2_score;
  logic [1:0] match_winner;
  logic       handshake_err;

  rally_sequencer #(
    .FRAME_DIV(FD),
    .SERVE_FRAMES(SF),
    .POINT_FRAMES(PF),
    .WIN_SCORE(WS)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .pause(pause),
    .btn_in(btn_in),
    .phys_game_over(phys_game_over),
    .phys_winner(phys_winner),
    .phys_valid(phys_valid),
    .btn_out(btn_out),
    .phys_en(phys_en),
    .phys_rst_n(phys_rst_n),
    .state(state),
    .p1_score(p1_score),
    .p2_score(p2_score),
    .match_winner(match_winner),
    .handshake_err(handshake_err)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int          cyc      = 0;   // edges since last reset release; divider == cyc % FD
  bit          auto_valid = 1'b0;
  bit          en_seen    = 1'b0;

  typedef struct {
    string       name;
    logic [31:0] value;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic       pause;
    logic [7:0] btn;
    logic [7:0] exp_btn;
  } btn_vec_t;

  typedef struct {
    logic [1:0] winner;
    logic [3:0] p1;
    logic [3:0] p2;
    logic [2:0] next;
    logic [1:0] mw;
  } rally_t;

  // Engine stand-in: answers each frame enable with phys_valid in the next cycle.
  always @(negedge clk) begin
    phys_valid = auto_valid && en_seen;
    en_seen    = phys_en;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, " state"},         32'(state),         32'(S_IDLE));
    check({tag, " p1_score"},      32'(p1_score),      32'd0);
    check({tag, " p2_score"},      32'(p2_score),      32'd0);
    check({tag, " match_winner"},  32'(match_winner),  32'd0);
    check({tag, " phys_en"},       32'(phys_en),       32'd0);
    check({tag, " phys_rst_n"},    32'(phys_rst_n),    32'd0);
    check({tag, " btn_out"},       32'(btn_out),       32'd0);
    check({tag, " handshake_err"}, 32'(handshake_err), 32'd0);
  endtask

  task automatic wait_state(input logic [2:0] s, input int unsigned bound, input string name);
    int unsigned n = 0;
    while (state !== s && n < bound) begin
      step();
      n++;
    end
    check(name, 32'(state), 32'(s));
  endtask

  task automatic run_rally(input rally_t r);
    int p_edge;
    int exp_exit;
    int exit_edge = -1;
    wait_state(S_PLAY, 40, "rally reaches PLAY");
    phys_game_over = 1'b1;
    phys_winner    = r.winner;
    step();
    p_edge = cyc;
    check("point entry state", 32'(state),    32'(S_POINT));
    check("point entry p1",    32'(p1_score), 32'(r.p1));
    check("point entry p2",    32'(p2_score), 32'(r.p2));
    exp_exit = (p_edge / int'(FD) + int'(PF)) * int'(FD);
    for (int i = 0; i < 20; i++) begin
      if (i == 9) phys_game_over = 1'b0;
      step();
      if (state !== S_POINT) begin
        exit_edge = cyc;
        break;
      end
    end
    phys_game_over = 1'b0;
    check("point exit edge",  32'(exit_edge),    32'(exp_exit));
    check("point exit state", 32'(state),        32'(r.next));
    check("point exit p1",    32'(p1_score),     32'(r.p1));
    check("point exit p2",    32'(p2_score),     32'(r.p2));
    check("point exit mw",    32'(match_winner), 32'(r.mw));
    check("point exit rst",   32'(phys_rst_n),   (r.next == S_SERVE) ? 32'd0 : 32'd1);
    step();
    check("post exit rst",    32'(phys_rst_n),   32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL global timeout: simulation did not complete, expected $finish");
    $fatal(1, "timeout");
  end

  initial begin
    btn_vec_t  bvec[6];
    rally_t    rv[5];
    exp_t      e;
    int        s_edge;

    bvec[0] = '{1'b0, 8'hA5, 8'hA5};
    bvec[1] = '{1'b1, 8'hA5, 8'h00};
    bvec[2] = '{1'b0, 8'h3C, 8'h3C};
    bvec[3] = '{1'b0, 8'hFF, 8'hFF};
    bvec[4] = '{1'b1, 8'hFF, 8'h00};
    bvec[5] = '{1'b0, 8'h00, 8'h00};

    rv[0] = '{2'd1, 4'd1, 4'd0, S_SERVE, 2'd0};
    rv[1] = '{2'd0, 4'd1, 4'd0, S_SERVE, 2'd0};
    rv[2] = '{2'd3, 4'd1, 4'd0, S_SERVE, 2'd0};
    rv[3] = '{2'd2, 4'd1, 4'd1, S_SERVE, 2'd0};
    rv[4] = '{2'd2, 4'd1, 4'd2, S_OVER,  2'd2};

    rst_n = 1'b0; start = 1'b0; pause = 1'b0; btn_in = 8'h00;
    phys_game_over = 1'b0; phys_winner = 2'd0;
    auto_valid = 1'b1;

    // Reset and release
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("reset");
    rst_n = 1'b1;
    cyc = 0;
    step();
    check("rst release phys_rst_n", 32'(phys_rst_n), 32'd1);
    check("rst release state",      32'(state),      32'(S_IDLE));

    // Test 1: start, serve delay, frame period, button pass-through
    start = 1'b1;
    step();
    check("start state",      32'(state),      32'(S_SERVE));
    check("start phys_rst_n", 32'(phys_rst_n), 32'd0);
    start  = 1'b0;
    btn_in = 8'hA5;
    s_edge = cyc;
    step();
    check("start pulse ends", 32'(phys_rst_n), 32'd1);
    for (int i = 0; i < 12; i++) begin
      check("serve phys_en", 32'(phys_en), 32'd0);
      check("serve btn_out", 32'(btn_out), 32'd0);
      if (state === S_PLAY) break;
      step();
    end
    check("serve->play edge", 32'(cyc),   32'((s_edge / int'(FD) + int'(SF)) * int'(FD)));
    check("play state",       32'(state), 32'(S_PLAY));
    for (int i = 0; i < 8; i++) begin
      step();
      check("play phys_en period", 32'(phys_en), 32'(cyc % int'(FD) == 0));
    end
    check("play btn_out", 32'(btn_out), 32'h A5);

    // Test 2: button gating table, then a long pause
    foreach (bvec[i]) begin
      pause  = bvec[i].pause;
      btn_in = bvec[i].btn;
      sb.push_back('{$sformatf("btn row %0d", i), 32'(bvec[i].exp_btn)});
      sb.push_back('{$sformatf("btn row %0d state", i), 32'(S_PLAY)});
      step();
      e = sb.pop_front();
      check(e.name, 32'(btn_out), e.value);
      e = sb.pop_front();
      check(e.name, 32'(state), e.value);
    end
    pause  = 1'b1;
    btn_in = 8'h5A;
    for (int i = 0; i < 12; i++) begin
      step();
      check("paused phys_en", 32'(phys_en), 32'd0);
      check("paused btn_out", 32'(btn_out), 32'd0);
      check("paused state",   32'(state),   32'(S_PLAY));
    end
    pause = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      check("resume phys_en", 32'(phys_en), 32'(cyc % int'(FD) == 0));
    end
    check("resume btn_out", 32'(btn_out), 32'h5A);
    btn_in = 8'h00;

    // Tests 3-5: rallies through to match end
    foreach (rv[i]) run_rally(rv[i]);
    for (int i = 0; i < 3; i++) begin
      step();
      check("over holds state", 32'(state),        32'(S_OVER));
      check("over holds mw",    32'(match_winner), 32'd2);
      check("over holds p2",    32'(p2_score),     32'd2);
    end
    start = 1'b1;
    step();
    check("restart state",      32'(state),        32'(S_SERVE));
    check("restart p1",         32'(p1_score),     32'd0);
    check("restart p2",         32'(p2_score),     32'd0);
    check("restart mw",         32'(match_winner), 32'd0);
    check("restart phys_rst_n", 32'(phys_rst_n),   32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("held start ignored",   32'(state),      32'(S_SERVE));
      check("held start no pulse",  32'(phys_rst_n), 32'd1);
    end
    start = 1'b0;

    // Test 6: handshake watchdog, then asynchronous reset mid-play
    wait_state(S_PLAY, 20, "wd reaches PLAY");
    for (int i = 0; i < 8; i++) begin
      if (phys_en === 1'b1) break;
      step();
    end
    check("wd pulse seen", 32'(phys_en), 32'd1);
    auto_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      check("wd window no err", 32'(handshake_err), 32'd0);
    end
    step();
    check("wd err on 5th cycle", 32'(handshake_err), 32'd1);
    repeat (6) step();
    check("wd err sticky", 32'(handshake_err), 32'd1);
    check("wd state play", 32'(state),         32'(S_PLAY));
    rst_n = 1'b0;
    #2;
    check_reset("async reset");
    @(negedge clk);
    rst_n = 1'b1;
    auto_valid = 1'b1;
    cyc = 0;
    step();
    check("rerelease phys_rst_n", 32'(phys_rst_n),    32'd1);
    check("rerelease state",      32'(state),         32'(S_IDLE));
    check("rerelease err",        32'(handshake_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
